// File: rtl/bitfusion_ctrl.sv
// Tile sequencer for an N x N bit-fusion systolic array: fills IBUF/WBUF from a
// valid/ready stream, clears accumulators, issues skewed read enables, then drains.
module bitfusion_ctrl #(
  parameter int ARRAY_SIZE = 2,
  parameter int DATA_W     = 32,
  parameter int DRAIN      = 2
) (
  input  logic                             clk,
  input  logic                             RST,
  input  logic                             start,
  input  logic [2:0]                       cfg_ibw,
  input  logic [2:0]                       cfg_wbw,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATA_W-1:0]                in_data,
  output logic [DATA_W-1:0]                data_in,
  output logic [ARRAY_SIZE-1:0]            IBUF_wr_en,
  output logic [ARRAY_SIZE*ARRAY_SIZE-1:0] WBUF_wr_en,
  output logic [ARRAY_SIZE-1:0]            input_rd_en,
  output logic [ARRAY_SIZE*ARRAY_SIZE-1:0] weight_rd_en,
  output logic [ARRAY_SIZE-1:0]            acc_clear,
  output logic [2:0]                       input_bitwidth,
  output logic [2:0]                       weight_bitwidth,
  output logic                             busy,
  output logic                             done,
  output logic                             cfg_err
);

  localparam int N  = ARRAY_SIZE;
  localparam int LW = $clog2(N * N + 1);
  localparam int TW = $clog2(2 * N + DRAIN + 8) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_I, S_LOAD_W, S_CLEAR, S_COMPUTE, S_DRAIN, S_DONE
  } state_t;

  state_t            state, next_state;
  logic [TW-1:0]     t;
  logic [LW-1:0]     lcnt;
  logic              accept, cfg_ok;
  logic [N-1:0]      ibuf_hot;
  logic [N*N-1:0]    wbuf_hot;
  int                k, compute_last;

  function automatic logic legal_code(input logic [2:0] code);
    return (code == 3'b001) || (code == 3'b010) || (code == 3'b100);
  endfunction

  assign cfg_ok    = legal_code(cfg_ibw) && legal_code(cfg_wbw);
  assign in_ready  = (state == S_LOAD_I) || (state == S_LOAD_W);
  assign accept    = in_valid && in_ready;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign acc_clear = {N{state == S_CLEAR}};

  always_comb begin
    k = 4;
    case (weight_bitwidth)
      3'b001:  k = 1;
      3'b010:  k = 2;
      default: k = 4;
    endcase
    compute_last = 2 * (N - 1) + k - 1;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (start && cfg_ok) next_state = S_LOAD_I;
      S_LOAD_I:  if (accept && int'(lcnt) == N - 1) next_state = S_LOAD_W;
      S_LOAD_W:  if (accept && int'(lcnt) == N * N - 1) next_state = S_CLEAR;
      S_CLEAR:   next_state = S_COMPUTE;
      S_COMPUTE: if (int'(t) == compute_last) next_state = (DRAIN > 0) ? S_DRAIN : S_DONE;
      S_DRAIN:   if (int'(t) == DRAIN - 1) next_state = S_DONE;
      S_DONE:    next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Write strobes are one-hot on the beat index; WBUF is row-major, bit r*N+c.
  always_comb begin
    ibuf_hot = '0;
    wbuf_hot = '0;
    for (int i = 0; i < N; i++) ibuf_hot[i] = (int'(lcnt) == i);
    for (int i = 0; i < N * N; i++) wbuf_hot[i] = (int'(lcnt) == i);
  end

  // FU (r,c) sees its wavefront r+c steps after the first, for K beats.
  always_comb begin
    input_rd_en  = '0;
    weight_rd_en = '0;
    if (state == S_COMPUTE) begin
      for (int r = 0; r < N; r++) begin
        input_rd_en[r] = (r <= int'(t)) && (int'(t) < r + k);
        for (int c = 0; c < N; c++)
          weight_rd_en[r*N+c] = (r + c <= int'(t)) && (int'(t) < r + c + k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state           <= S_IDLE;
      t               <= '0;
      lcnt            <= '0;
      data_in         <= '0;
      IBUF_wr_en      <= '0;
      WBUF_wr_en      <= '0;
      input_bitwidth  <= '0;
      weight_bitwidth <= '0;
      cfg_err         <= 1'b0;
    end else begin
      state      <= next_state;
      IBUF_wr_en <= '0;
      WBUF_wr_en <= '0;
      cfg_err    <= (state == S_IDLE) && start && !cfg_ok;
      if (state == S_IDLE && start && cfg_ok) begin
        input_bitwidth  <= cfg_ibw;
        weight_bitwidth <= cfg_wbw;
      end
      if (accept) begin
        data_in <= in_data;
        lcnt    <= (next_state != state) ? '0 : lcnt + LW'(1);
        if (state == S_LOAD_I) IBUF_wr_en <= ibuf_hot;
        else                   WBUF_wr_en <= wbuf_hot;
      end
      if (next_state != state)
        t <= '0;
      else if (state == S_COMPUTE || state == S_DRAIN)
        t <= t + TW'(1);
    end
  end

endmodule

// File: tb/tb_bitfusion_ctrl.sv
// Directed, table-driven bench for bitfusion_ctrl at N=2: one vector per clock,
// plus a hand sequence covering reset in the middle of COMPUTE.
module tb_bitfusion_ctrl;

  logic        clk = 1'b0;
  logic        RST;
  logic        start;
  logic [2:0]  cfg_ibw, cfg_wbw;
  logic        in_valid, in_ready;
  logic [31:0] in_data, data_in;
  logic [1:0]  IBUF_wr_en, input_rd_en, acc_clear;
  logic [3:0]  WBUF_wr_en, weight_rd_en;
  logic [2:0]  input_bitwidth, weight_bitwidth;
  logic        busy, done, cfg_err;

  int compared = 0;
  int failed   = 0;

  bitfusion_ctrl #(.ARRAY_SIZE(2), .DATA_W(32), .DRAIN(2)) dut (
    .clk(clk), .RST(RST), .start(start), .cfg_ibw(cfg_ibw), .cfg_wbw(cfg_wbw),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .data_in(data_in),
    .IBUF_wr_en(IBUF_wr_en), .WBUF_wr_en(WBUF_wr_en), .input_rd_en(input_rd_en),
    .weight_rd_en(weight_rd_en), .acc_clear(acc_clear),
    .input_bitwidth(input_bitwidth), .weight_bitwidth(weight_bitwidth),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [2:0]  ib, wb;
    logic        vld;
    logic [31:0] dat;
    logic        rdy, bsy, dn, err;
    logic [1:0]  acc, ibuf;
    logic [3:0]  wbuf;
    logic [1:0]  ird;
    logic [3:0]  wrd;
    logic [31:0] din;
    logic [2:0]  eib, ewb;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] I7 = 32'h7f7f7f7f;
  localparam logic [31:0] W7 = 32'h77777777;

  function automatic vec_t mk(
    input logic st, input logic [2:0] ib, wb, input logic vld, input logic [31:0] dat,
    input logic rdy, bsy, dn, err, input logic [1:0] acc, ibuf, input logic [3:0] wbuf,
    input logic [1:0] ird, input logic [3:0] wrd, input logic [31:0] din,
    input logic [2:0] eib, ewb);
    vec_t v;
    v.st = st; v.ib = ib; v.wb = wb; v.vld = vld; v.dat = dat;
    v.rdy = rdy; v.bsy = bsy; v.dn = dn; v.err = err; v.acc = acc; v.ibuf = ibuf;
    v.wbuf = wbuf; v.ird = ird; v.wrd = wrd; v.din = din; v.eib = eib; v.ewb = ewb;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    start    = v.st;
    cfg_ibw  = v.ib;
    cfg_wbw  = v.wb;
    in_valid = v.vld;
    in_data  = v.dat;
  endtask

  task automatic checkVec(input vec_t v, input int idx);
    checkOutput($sformatf("v%0d in_ready", idx), 32'(in_ready), 32'(v.rdy));
    checkOutput($sformatf("v%0d busy", idx), 32'(busy), 32'(v.bsy));
    checkOutput($sformatf("v%0d done", idx), 32'(done), 32'(v.dn));
    checkOutput($sformatf("v%0d cfg_err", idx), 32'(cfg_err), 32'(v.err));
    checkOutput($sformatf("v%0d acc_clear", idx), 32'(acc_clear), 32'(v.acc));
    checkOutput($sformatf("v%0d IBUF_wr_en", idx), 32'(IBUF_wr_en), 32'(v.ibuf));
    checkOutput($sformatf("v%0d WBUF_wr_en", idx), 32'(WBUF_wr_en), 32'(v.wbuf));
    checkOutput($sformatf("v%0d input_rd_en", idx), 32'(input_rd_en), 32'(v.ird));
    checkOutput($sformatf("v%0d weight_rd_en", idx), 32'(weight_rd_en), 32'(v.wrd));
    checkOutput($sformatf("v%0d data_in", idx), data_in, v.din);
    checkOutput($sformatf("v%0d input_bitwidth", idx), 32'(input_bitwidth), 32'(v.eib));
    checkOutput($sformatf("v%0d weight_bitwidth", idx), 32'(weight_bitwidth), 32'(v.ewb));
  endtask

  task automatic runVecs(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      applyStimulus(vecs[i]);
      checkVec(vecs[i], i);
      step();
    end
  endtask

  initial begin
    // Tile with ibw=100, wbw=010 (K=2); start pulses in COMPUTE and DONE are ignored.
    //              st ib      wb      vld dat            rdy bsy dn err acc    ibuf   wbuf     ird    wrd      din            eib     ewb
    vecs.push_back(mk(1, 3'b100, 3'b010, 0, 32'h0,        0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b0000, 32'h0,        3'b000, 3'b000)); // 0
    vecs.push_back(mk(0, 3'b000, 3'b000, 1, I7,           1, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b0000, 32'h0,        3'b100, 3'b010)); // 1
    vecs.push_back(mk(0, 3'b111, 3'b111, 1, I7,           1, 1, 0, 0, 2'b00, 2'b01, 4'b0000, 2'b00, 4'b0000, I7,           3'b100, 3'b010)); // 2
    vecs.push_back(mk(0, 3'b000, 3'b000, 1, W7,           1, 1, 0, 0, 2'b00, 2'b10, 4'b0000, 2'b00, 4'b0000, I7,           3'b100, 3'b010)); // 3
    vecs.push_back(mk(0, 3'b000, 3'b000, 1, W7,           1, 1, 0, 0, 2'b00, 2'b00, 4'b0001, 2'b00, 4'b0000, W7,           3'b100, 3'b010)); // 4
    vecs.push_back(mk(0, 3'b000, 3'b000, 1, W7,           1, 1, 0, 0, 2'b00, 2'b00, 4'b0010, 2'b00, 4'b0000, W7,           3'b100, 3'b010)); // 5
    vecs.push_back(mk(0, 3'b000, 3'b000, 1, W7,           1, 1, 0, 0, 2'b00, 2'b00, 4'b0100, 2'b00, 4'b0000, W7,           3'b100, 3'b010)); // 6
    vecs.push_back(mk(0, 3'b000, 3'b000, 0, 32'h0,        0, 1, 0, 0, 2'b11, 2'b00, 4'b1000, 2'b00, 4'b0000, W7,           3'b100, 3'b010)); // 7 CLEAR
    vecs.push_back(mk(0, 3'b000, 3'b000, 0, 32'h0,        0, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 2'b01, 4'b0001, W7,           3'b100, 3'b010)); // 8 t0
    vecs.push_back(mk(1, 3'b100, 3'b100, 0, 32'h0,        0, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 2'b11, 4'b0111, W7,           3'b100, 3'b010)); // 9 t1
    vecs.push_back(mk(0, 3'b000, 3'b000, 0, 32'h0,        0, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 2'b10, 4'b1110, W7,           3'b100, 3'b010)); // 10 t2
    vecs.push_back(mk(0, 3'b000, 3'b000, 0, 32'h0,        0, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b1000, W7,           3'b100, 3'b010)); // 11 t3
    vecs.push_back(mk(0, 3'b000, 3'b000, 0, 32'h0,        0, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b0000, W7,           3'b100, 3'b010)); // 12 drain
    vecs.push_back(mk(0, 3'b000, 3'b000, 0, 32'h0,        0, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b0000, W7,           3'b100, 3'b010)); // 13 drain
    vecs.push_back(mk(1, 3'b100, 3'b010, 0, 32'h0,        0, 1, 1, 0, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b0000, W7,           3'b100, 3'b010)); // 14 DONE
    vecs.push_back(mk(1, 3'b011, 3'b001, 0, 32'h0,        0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b0000, W7,           3'b100, 3'b010)); // 15 IDLE, illegal cfg
    // Illegal cfg pulse, then a K=1 tile with a 3-cycle valid gap after the first IBUF beat.
    vecs.push_back(mk(1, 3'b001, 3'b001, 0, 32'h0,        0, 0, 0, 1, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b0000, W7,           3'b100, 3'b010)); // 16
    vecs.push_back(mk(0, 3'b000, 3'b000, 1, 32'ha1,       1, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b0000, W7,           3'b001, 3'b001)); // 17
    vecs.push_back(mk(0, 3'b000, 3'b000, 0, 32'hdead,     1, 1, 0, 0, 2'b00, 2'b01, 4'b0000, 2'b00, 4'b0000, 32'ha1,       3'b001, 3'b001)); // 18
    vecs.push_back(mk(0, 3'b000, 3'b000, 0, 32'hdead,     1, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b0000, 32'ha1,       3'b001, 3'b001)); // 19
    vecs.push_back(mk(0, 3'b000, 3'b000, 0, 32'hdead,     1, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b0000, 32'ha1,       3'b001, 3'b001)); // 20
    vecs.push_back(mk(0, 3'b000, 3'b000, 1, 32'ha2,       1, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b0000, 32'ha1,       3'b001, 3'b001)); // 21
    vecs.push_back(mk(0, 3'b000, 3'b000, 1, 32'hb0,       1, 1, 0, 0, 2'b00, 2'b10, 4'b0000, 2'b00, 4'b0000, 32'ha2,       3'b001, 3'b001)); // 22
    vecs.push_back(mk(0, 3'b000, 3'b000, 1, 32'hb1,       1, 1, 0, 0, 2'b00, 2'b00, 4'b0001, 2'b00, 4'b0000, 32'hb0,       3'b001, 3'b001)); // 23
    vecs.push_back(mk(0, 3'b000, 3'b000, 1, 32'hb2,       1, 1, 0, 0, 2'b00, 2'b00, 4'b0010, 2'b00, 4'b0000, 32'hb1,       3'b001, 3'b001)); // 24
    vecs.push_back(mk(0, 3'b000, 3'b000, 1, 32'hb3,       1, 1, 0, 0, 2'b00, 2'b00, 4'b0100, 2'b00, 4'b0000, 32'hb2,       3'b001, 3'b001)); // 25
    vecs.push_back(mk(0, 3'b000, 3'b000, 1, 32'heeee,     0, 1, 0, 0, 2'b11, 2'b00, 4'b1000, 2'b00, 4'b0000, 32'hb3,       3'b001, 3'b001)); // 26 CLEAR
    vecs.push_back(mk(0, 3'b000, 3'b000, 0, 32'h0,        0, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 2'b01, 4'b0001, 32'hb3,       3'b001, 3'b001)); // 27 t0
    vecs.push_back(mk(0, 3'b000, 3'b000, 0, 32'h0,        0, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 2'b10, 4'b0110, 32'hb3,       3'b001, 3'b001)); // 28 t1
    vecs.push_back(mk(0, 3'b000, 3'b000, 0, 32'h0,        0, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b1000, 32'hb3,       3'b001, 3'b001)); // 29 t2
    vecs.push_back(mk(0, 3'b000, 3'b000, 0, 32'h0,        0, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b0000, 32'hb3,       3'b001, 3'b001)); // 30
    vecs.push_back(mk(0, 3'b000, 3'b000, 0, 32'h0,        0, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b0000, 32'hb3,       3'b001, 3'b001)); // 31
    vecs.push_back(mk(0, 3'b000, 3'b000, 0, 32'h0,        0, 1, 1, 0, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b0000, 32'hb3,       3'b001, 3'b001)); // 32 DONE
    vecs.push_back(mk(0, 3'b000, 3'b000, 0, 32'h0,        0, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 2'b00, 4'b0000, 32'hb3,       3'b001, 3'b001)); // 33

    RST = 1'b1; start = 1'b0; cfg_ibw = 3'b000; cfg_wbw = 3'b000; in_valid = 1'b0; in_data = 32'h0;
    step();
    step();
    RST = 1'b0;
    runVecs(0, vecs.size() - 1);

    // K=4 tile, reset asserted at COMPUTE t=1 together with a start request.
    start = 1'b1; cfg_ibw = 3'b100; cfg_wbw = 3'b100;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h1000 + 32'(i);
      step();
    end
    in_valid = 1'b0;
    checkOutput("rst_seq acc_clear", 32'(acc_clear), 32'h3);
    step();
    step();
    checkOutput("rst_seq t1 input_rd_en", 32'(input_rd_en), 32'h3);
    checkOutput("rst_seq t1 weight_rd_en", 32'(weight_rd_en), 32'h7);
    RST = 1'b1; start = 1'b1; cfg_ibw = 3'b010; cfg_wbw = 3'b010;
    step();
    checkOutput("rst busy", 32'(busy), 32'h0);
    checkOutput("rst input_rd_en", 32'(input_rd_en), 32'h0);
    checkOutput("rst weight_rd_en", 32'(weight_rd_en), 32'h0);
    checkOutput("rst in_ready", 32'(in_ready), 32'h0);
    checkOutput("rst data_in", data_in, 32'h0);
    checkOutput("rst input_bitwidth", 32'(input_bitwidth), 32'h0);
    checkOutput("rst weight_bitwidth", 32'(weight_bitwidth), 32'h0);
    RST = 1'b0; start = 1'b0;
    step();
    checkOutput("rst start ignored busy", 32'(busy), 32'h0);
    runVecs(0, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
